// File: rtl/vector_exec_unit.sv
// Multi-cycle SIMD vector ALU: LANES elements per RUN cycle over a VLEN-bit register.
// Optional feature macro: VECTOR_MASK_EN (per-element write masking via vm/mask).
module vector_exec_unit #(
    parameter int VLEN  = 128,
    parameter int LANES = 4
) (
    input  logic            SYS_clk,
    input  logic            SYS_reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [2:0]      vsew,
    input  logic [31:0]     vl,
    input  logic [31:0]     vstart,
    input  logic [VLEN-1:0] vs2_data,
    input  logic [VLEN-1:0] vs1_data,
    input  logic [VLEN-1:0] old_vd,
    input  logic [31:0]     scalar,
    input  logic            use_scalar,
    input  logic            vm,
    input  logic [VLEN-1:0] mask,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [VLEN-1:0] result,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     idx_q, end_q;
    logic [2:0]      op_q;
    logic [1:0]      sew_q;
    logic            use_scalar_q, illegal_q;
    logic [VLEN-1:0] a_q, b_q, res_q, res_d;
    logic [31:0]     scalar_q;

`ifdef VECTOR_MASK_EN
    logic            vm_q;
    logic [VLEN-1:0] mask_q;
`else
    wire unused_mask_ports = &{1'b0, vm, mask};
`endif

    // Start-time decode: VLMAX = VLEN/SEW, so vl above it is silently capped.
    logic        sew_legal, go_run;
    logic [31:0] vlmax, end_in;

    always_comb begin
        sew_legal = (vsew <= 3'd2);
        vlmax     = 32'(VLEN) >> (32'd3 + {29'd0, vsew});
        end_in    = (vl < vlmax) ? vl : vlmax;
        go_run    = sew_legal && (vstart < end_in);
    end

    function automatic logic [31:0] alu(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] shmask);
        logic [4:0] sh;
        sh = b[4:0] & shmask;
        case (f)
            3'd0:    alu = a + b;
            3'd1:    alu = a - b;
            3'd2:    alu = a & b;
            3'd3:    alu = a | b;
            3'd4:    alu = a ^ b;
            3'd5:    alu = a << sh;
            3'd6:    alu = a >> sh;
            default: alu = a * b;
        endcase
    endfunction

    // Operands are zero-extended to 32 bits so srl is logical at every SEW.
    logic [31:0] e, r, bs;
    logic        wen;

    always_comb begin
        res_d = res_q;
        e     = '0;
        r     = '0;
        bs    = '0;
        wen   = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            e = idx_q + 32'(l);
`ifdef VECTOR_MASK_EN
            wen = (e < end_q) && (vm_q || mask_q[e]);
`else
            wen = (e < end_q);
`endif
            if (wen) begin
                case (sew_q)
                    2'd0: begin
                        bs = use_scalar_q ? {24'd0, scalar_q[7:0]} : {24'd0, b_q[e*8 +: 8]};
                        r  = alu(op_q, {24'd0, a_q[e*8 +: 8]}, bs, 5'd7);
                        res_d[e*8 +: 8] = r[7:0];
                    end
                    2'd1: begin
                        bs = use_scalar_q ? {16'd0, scalar_q[15:0]} : {16'd0, b_q[e*16 +: 16]};
                        r  = alu(op_q, {16'd0, a_q[e*16 +: 16]}, bs, 5'd15);
                        res_d[e*16 +: 16] = r[15:0];
                    end
                    default: begin
                        bs = use_scalar_q ? scalar_q : b_q[e*32 +: 32];
                        r  = alu(op_q, a_q[e*32 +: 32], bs, 5'd31);
                        res_d[e*32 +: 32] = r;
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = go_run ? S_RUN : S_DONE;
            S_RUN:   if (idx_q + 32'(LANES) >= end_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            end_q        <= '0;
            op_q         <= '0;
            sew_q        <= '0;
            use_scalar_q <= 1'b0;
            illegal_q    <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            scalar_q     <= '0;
            res_q        <= '0;
`ifdef VECTOR_MASK_EN
            vm_q         <= 1'b0;
            mask_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                // Result starts as old_vd so prefix/tail elements are undisturbed.
                idx_q        <= vstart;
                end_q        <= end_in;
                op_q         <= op;
                sew_q        <= vsew[1:0];
                use_scalar_q <= use_scalar;
                illegal_q    <= ~sew_legal;
                a_q          <= vs2_data;
                b_q          <= vs1_data;
                scalar_q     <= scalar;
                res_q        <= old_vd;
`ifdef VECTOR_MASK_EN
                vm_q         <= vm;
                mask_q       <= mask;
`endif
            end else if (state_q == S_RUN) begin
                res_q <= res_d;
                idx_q <= idx_q + 32'(LANES);
            end
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign illegal   = done && illegal_q;
    assign result    = res_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Table-driven directed bench for vector_exec_unit (VLEN=128, LANES=4),
// plus hand-written reset-abort and start-while-busy sequences.
module tb_vector_exec_unit;
    localparam int VLEN = 128;

    logic            SYS_clk = 1'b0;
    logic            SYS_reset;
    logic            start;
    logic [2:0]      op, vsew;
    logic [31:0]     vl, vstart, scalar;
    logic [VLEN-1:0] vs2_data, vs1_data, old_vd, mask;
    logic            use_scalar, vm;
    logic            busy, done, illegal;
    logic [VLEN-1:0] result;
    logic [1:0]      dbg_state;

    vector_exec_unit #(.VLEN(VLEN), .LANES(4)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .start(start), .op(op), .vsew(vsew),
        .vl(vl), .vstart(vstart), .vs2_data(vs2_data), .vs1_data(vs1_data),
        .old_vd(old_vd), .scalar(scalar), .use_scalar(use_scalar), .vm(vm),
        .mask(mask), .busy(busy), .done(done), .illegal(illegal), .result(result),
        .dbg_state(dbg_state)
    );

    always #5 SYS_clk = ~SYS_clk;

    typedef struct {
        string           name;
        logic [2:0]      op;
        logic [2:0]      vsew;
        logic [31:0]     vl;
        logic [31:0]     vstart;
        logic [VLEN-1:0] a;
        logic [VLEN-1:0] b;
        logic [31:0]     scalar;
        logic            use_scalar;
        logic            vm;
        logic [VLEN-1:0] mask;
        logic [VLEN-1:0] old_vd;
        logic [VLEN-1:0] exp_res;
        int              exp_lat;
        logic            exp_ill;
    } vec_t;

    vec_t vecs[10];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge SYS_clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        op = v.op; vsew = v.vsew; vl = v.vl; vstart = v.vstart;
        vs2_data = v.a; vs1_data = v.b; scalar = v.scalar;
        use_scalar = v.use_scalar; vm = v.vm; mask = v.mask; old_vd = v.old_vd;
    endtask

    task automatic scramble();
        op = 3'($urandom_range(0, 7)); vsew = 3'($urandom_range(0, 7));
        vl = $urandom(); vstart = $urandom(); scalar = $urandom();
        use_scalar = 1'($urandom_range(0, 1)); vm = 1'($urandom_range(0, 1));
        vs2_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        vs1_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        old_vd   = {$urandom(), $urandom(), $urandom(), $urandom()};
        mask     = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Waits for done; returns cycles counted from the start edge (1 = done right after it).
    task automatic wait_done(output int cycles);
        cycles = 1;
        while (!done && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        drive(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble();
        chk({v.name, " busy_after_start"}, VLEN'(busy), VLEN'(v.exp_lat > 1));
        wait_done(lat);
        chk({v.name, " latency"}, VLEN'(lat), VLEN'(v.exp_lat));
        chk({v.name, " result"}, result, v.exp_res);
        chk({v.name, " illegal"}, VLEN'(illegal), VLEN'(v.exp_ill));
        tick();
        chk({v.name, " done_pulse"}, VLEN'(done), VLEN'(0));
    endtask

    initial begin
        logic [VLEN-1:0] xor_exp;
        int lat;
        vecs[0] = '{"add32", 3'd0, 3'd2, 32'd4, 32'd0,
                    {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
                    32'd0, 1'b0, 1'b1, '0, '0,
                    {32'd44, 32'd33, 32'd22, 32'd11}, 2, 1'b0};
        vecs[1] = '{"add8_cap", 3'd0, 3'd0, 32'd20, 32'd0,
                    {16{8'hFF}}, {16{8'h01}}, 32'd0, 1'b0, 1'b1, '0, {16{8'h33}},
                    '0, 5, 1'b0};
        vecs[2] = '{"sub32_scalar", 3'd1, 3'd2, 32'd5, 32'd2,
                    {32'd8, 32'd7, 32'd6, 32'd5}, {4{32'h99}}, 32'd1, 1'b1, 1'b1, '0,
                    {4{32'hAAAAAAAA}}, {32'd7, 32'd6, 32'hAAAAAAAA, 32'hAAAAAAAA}, 2, 1'b0};
        vecs[3] = '{"illegal_sew", 3'd0, 3'd3, 32'd4, 32'd0,
                    {4{32'h11}}, {4{32'h22}}, 32'd0, 1'b0, 1'b1, '0, {4{32'hDEADBEEF}},
                    {4{32'hDEADBEEF}}, 1, 1'b1};
        vecs[4] = '{"sll8", 3'd5, 3'd0, 32'd16, 32'd0,
                    {16{8'h81}}, {16{8'h09}}, 32'd0, 1'b0, 1'b1, '0, '0,
                    {16{8'h02}}, 5, 1'b0};
        vecs[5] = '{"srl16", 3'd6, 3'd1, 32'd8, 32'd0,
                    {8{16'h8000}}, {8{16'h0013}}, 32'd0, 1'b0, 1'b1, '0, '0,
                    {8{16'h1000}}, 3, 1'b0};
        vecs[6] = '{"mul16_tail", 3'd7, 3'd1, 32'd3, 32'd0,
                    {8{16'h0100}}, {8{16'h0101}}, 32'd0, 1'b0, 1'b1, '0, {8{16'h5555}},
                    {{5{16'h5555}}, {3{16'h0100}}}, 2, 1'b0};
        vecs[7] = '{"or_vl0", 3'd3, 3'd2, 32'd0, 32'd0,
                    {4{32'hFFFF}}, {4{32'hFFFF}}, 32'd0, 1'b0, 1'b1, '0, {4{32'h0BADF00D}},
                    {4{32'h0BADF00D}}, 1, 1'b0};
`ifdef VECTOR_MASK_EN
        xor_exp = {32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF};
`else
        xor_exp = {4{32'hFFFFFFFF}};
`endif
        vecs[8] = '{"xor32_mask", 3'd4, 3'd2, 32'd4, 32'd0,
                    {4{32'hF0F0F0F0}}, {4{32'h0F0F0F0F}}, 32'd0, 1'b0, 1'b0,
                    {{124{1'b0}}, 4'b0101}, {4{32'h12345678}}, xor_exp, 2, 1'b0};
        vecs[9] = '{"sub8_vstart_vm1", 3'd1, 3'd0, 32'd16, 32'd14,
                    '0, {16{8'h01}}, 32'd0, 1'b0, 1'b1, '0, '0,
                    {16'hFFFF, 112'd0}, 2, 1'b0};

        SYS_reset = 1'b1;
        start = 1'b0;
        scramble();
        tick();
        tick();
        chk("reset_busy", VLEN'(busy), '0);
        chk("reset_done", VLEN'(done), '0);
        chk("reset_illegal", VLEN'(illegal), '0);
        chk("reset_result", result, '0);
        chk("reset_state", VLEN'(dbg_state), '0);
        SYS_reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset in the middle of an SEW=8 vl=16 operation aborts it with no done.
        drive(vecs[1]);
        vl = 32'd16;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort_busy_before", VLEN'(busy), VLEN'(1));
        SYS_reset = 1'b1;
        tick();
        SYS_reset = 1'b0;
        chk("abort_busy", VLEN'(busy), '0);
        chk("abort_done", VLEN'(done), '0);
        chk("abort_result", result, '0);
        begin
            int seen_done = 0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (done) seen_done++;
            end
            chk("abort_no_done", VLEN'(seen_done), '0);
        end

        // start held high during RUN with new operands must not be queued or re-latched.
        drive(vecs[5]);
        start = 1'b1;
        tick();
        op = 3'd0;
        vs2_data = {4{32'h01010101}};
        old_vd = {4{32'h77777777}};
        wait_done(lat);
        start = 1'b0;
        chk("busy_start latency", VLEN'(lat), VLEN'(3));
        chk("busy_start result", result, {8{16'h1000}});
        tick();
        chk("busy_start idle", VLEN'(dbg_state), '0);
        tick();
        tick();
        chk("busy_start no_requeue", VLEN'(busy), '0);
        chk("busy_start held", result, {8{16'h1000}});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vector_exec_unit.md
VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 Parameter VLEN, default 128: bits per vector register; multiple of 32 and of 8*LANES.
REQ-002 Parameter LANES, default 4: elements processed per RUN cycle, 1..VLEN/32.
REQ-003 SYS_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SYS_reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 op  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 mul (low SEW bits).
REQ-007 vsew  in  3  000=8, 001=16, 010=32 bit elements; other codes illegal.
REQ-008 vl, vstart  in  32 each  element count and first element index.
REQ-009 vs2_data, vs1_data, old_vd  in  VLEN each  operand A, operand B, prior destination contents.
REQ-010 scalar, use_scalar  in  32, 1  when use_scalar=1, operand B is scalar[SEW-1:0] for every element.
REQ-011 vm, mask  in  1, VLEN  vm=0 enables masking; mask[i] governs element i.
REQ-012 busy  out  1  high in RUN.
REQ-013 done  out  1  one-cycle pulse in DONE.
REQ-014 illegal  out  1  high together with done for an illegal vsew.
REQ-015 result  out  VLEN  destination value; valid while done=1; held until next accepted start.

Function
REQ-016 Operands, op, vsew, use_scalar, vm, mask, old_vd SHALL be latched on the edge where start=1 in IDLE; later input changes have no effect.
REQ-017 FSM IDLE->RUN on start with legal vsew and vstart<end; IDLE->DONE on start with illegal vsew or vstart>=end; RUN->RUN while index+LANES<end; RUN->DONE otherwise; DONE->IDLE always.
REQ-018 end = min(vl, VLEN/SEW); vl above VLMAX SHALL be silently capped.
REQ-019 Index counter loads vstart on start; each RUN cycle computes elements index..index+LANES-1 that are <end, then adds LANES.
REQ-020 Latency: start edge to done high = ceil((end-vstart)/LANES)+1 cycles; = 1 cycle for IDLE->DONE paths.
REQ-021 Element i result = A_i op B_i modulo 2^SEW; sub is A-B; shifts use B_i[log2(SEW)-1:0]; srl logical.
REQ-022 Elements with i<vstart or i>=end SHALL retain old_vd (tail/prefix undisturbed).
REQ-023 Illegal vsew: result=old_vd, illegal=1 and done=1 for one cycle.
REQ-024 start during RUN or DONE SHALL be ignored, never queued.
REQ-025 SYS_reset mid-operation SHALL abort: next cycle IDLE, partial result discarded, no done.

Reset
REQ-026 On SYS_reset: state IDLE, index 0, busy 0, done 0, illegal 0, result 0, all latched operands 0.

Configuration
REQ-027 Macro VECTOR_MASK_EN defined: when latched vm=0, element i with mask[i]=0 retains old_vd; vm=1 writes all active elements.
REQ-028 VECTOR_MASK_EN undefined: vm and mask ports present but ignored; all active elements written; no mask storage inferred.

Verification (VLEN=128, LANES=4)
REQ-029 SEW=32, vl=4, vstart=0, add, A={1,2,3,4}, B={10,20,30,40} -> done 2 cycles after start, result={11,22,33,44}.
REQ-030 SEW=8, vl=20, add, all A=0xFF, B=0x01 -> vl capped to 16, 4 RUN cycles, done at cycle 5, all bytes 0x00.
REQ-031 SEW=32, vl=5, vstart=2, sub with use_scalar=1, scalar=1, A={5,6,7,8}, old_vd all 0xAAAAAAAA -> result={0xAAAAAAAA,0xAAAAAAAA,6,7}, done at cycle 2.
REQ-032 VECTOR_MASK_EN defined, SEW=32, vl=4, vm=0, mask[3:0]=0101, xor -> elements 1,3 equal old_vd, 0,2 computed; undefined -> all four computed.
REQ-033 vsew=011 -> done and illegal high 1 cycle after start, result=old_vd; SYS_reset asserted in RUN of an SEW=8 vl=16 op -> no done, busy 0 next cycle.
